// File: rtl/mix_engine.sv
// rtl/mix_engine.sv - fixed-point matrix-vector mixer with banked weight/bias ROMs
//
// Computes data_out = sat((W[bank] * data_in + bias[bank] << FRAC) >>> FRAC),
// N_LANES output neurons per group, DATA_N inputs per weight word.
//
// Ports:
//   clk, rst_n      single clock; rst_n is a synchronous ACTIVE-HIGH reset
//   run, state      start request and bank select, sampled when run is accepted
//   data_in         HID_DIM x N_LEN input vector
//   busy, valid     computation in progress / one-cycle result strobe
//   data_out        HID_DIM x N_LEN result vector (updates only when valid rises)
//   w_addr, w_data  weight ROM {bank, g, c}, 1-cycle read latency
//   b_addr, b_data  bias ROM {bank, g}, 1-cycle read latency
module mix_engine #(
    parameter  int HID_DIM   = 24,
    parameter  int DATA_N    = 8,
    parameter  int N_LEN     = 16,
    parameter  int N_LANES   = 4,
    parameter  int FRAC      = 8,
    parameter  int STATE_LEN = 3,
    parameter  int RELU      = 0,
    localparam int G         = HID_DIM / N_LANES,
    localparam int C         = HID_DIM / DATA_N,
    localparam int GW        = $clog2(G),
    localparam int CW        = $clog2(C)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              run,
    input  logic [STATE_LEN-1:0]              state,
    input  logic [HID_DIM*N_LEN-1:0]          data_in,
    output logic                              busy,
    output logic                              valid,
    output logic [HID_DIM*N_LEN-1:0]          data_out,
    output logic [STATE_LEN+GW+CW-1:0]        w_addr,
    input  logic [N_LANES*DATA_N*N_LEN-1:0]   w_data,
    output logic [STATE_LEN+GW-1:0]           b_addr,
    input  logic [N_LANES*N_LEN-1:0]          b_data
);

    localparam int AW = 2 * N_LEN + $clog2(HID_DIM) + 1;
    localparam logic signed [AW-1:0] SMAX = {{(AW-N_LEN+1){1'b0}}, {(N_LEN-1){1'b1}}};
    localparam logic signed [AW-1:0] SMIN = {{(AW-N_LEN+1){1'b1}}, {(N_LEN-1){1'b0}}};

    if (HID_DIM % DATA_N != 0) begin : g_bad_data_n
        $error("mix_engine: HID_DIM must be a multiple of DATA_N");
    end
    if (HID_DIM % N_LANES != 0) begin : g_bad_lanes
        $error("mix_engine: HID_DIM must be a multiple of N_LANES");
    end
    if (FRAC >= N_LEN) begin : g_bad_frac
        $error("mix_engine: FRAC must be smaller than N_LEN");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} st_t;

    st_t                        st_q, st_d;
    logic [GW-1:0]              g_q, g_d;
    logic [CW-1:0]              c_q, c_d;
    logic [STATE_LEN-1:0]       bank_q, bank_d;
    logic [HID_DIM*N_LEN-1:0]   data_q, data_d;
    logic                       rd_vld_q, rd_vld_d;
    logic [GW-1:0]              rd_g_q, rd_g_d;
    logic [CW-1:0]              rd_c_q, rd_c_d;
    logic signed [AW-1:0]       acc_q [N_LANES];
    logic signed [AW-1:0]       acc_d [N_LANES];
    logic [HID_DIM*N_LEN-1:0]   work_q, work_d;
    logic [HID_DIM*N_LEN-1:0]   out_q, out_d;
    logic                       busy_q, busy_d;
    logic                       valid_q, valid_d;
    logic [STATE_LEN+GW+CW-1:0] w_addr_q, w_addr_d;
    logic [STATE_LEN+GW-1:0]    b_addr_q, b_addr_d;

    always_comb begin : p_next
        logic                       run_ok;
        logic signed [2*N_LEN-1:0]  prod;
        logic signed [AW-1:0]       chunk;
        logic signed [AW-1:0]       sum;
        logic signed [AW-1:0]       bias_ext;
        logic signed [AW-1:0]       shr;
        logic [N_LEN-1:0]           res;

        st_d     = st_q;
        g_d      = g_q;
        c_d      = c_q;
        bank_d   = bank_q;
        data_d   = data_q;
        acc_d    = acc_q;
        work_d   = work_q;
        prod     = '0;
        chunk    = '0;
        sum      = '0;
        bias_ext = '0;
        shr      = '0;
        res      = '0;

        run_ok = run && (st_q == IDLE || st_q == DONE);

        // Control: walk (g, c) with c innermost, then one drain cycle for
        // the last ROM word to come back.
        case (st_q)
            IDLE, DONE: begin
                g_d  = '0;
                c_d  = '0;
                st_d = IDLE;
                if (run_ok) begin
                    st_d   = ISSUE;
                    bank_d = state;
                    data_d = data_in;
                end
            end
            ISSUE: begin
                if (c_q == CW'(C - 1)) begin
                    c_d = '0;
                    if (g_q == GW'(G - 1)) begin
                        g_d  = '0;
                        st_d = DRAIN;
                    end else begin
                        g_d = g_q + GW'(1);
                    end
                end else begin
                    c_d = c_q + CW'(1);
                end
            end
            DRAIN:   st_d = DONE;
            default: st_d = IDLE;
        endcase

        // Remember what was asked for so the word arriving next cycle can
        // be matched to its (g, c).
        rd_vld_d = (st_q == ISSUE);
        rd_g_d   = g_q;
        rd_c_d   = c_q;

        if (rd_vld_q) begin
            for (int l = 0; l < N_LANES; l++) begin
                chunk = '0;
                for (int k = 0; k < DATA_N; k++) begin
                    prod  = $signed(data_q[(int'(rd_c_q) * DATA_N + k) * N_LEN +: N_LEN])
                          * $signed(w_data[(l * DATA_N + k) * N_LEN +: N_LEN]);
                    chunk = chunk + AW'(prod);
                end
                // The first chunk of a group loads instead of accumulating.
                sum      = ((rd_c_q == '0) ? '0 : acc_q[l]) + chunk;
                acc_d[l] = sum;
                if (rd_c_q == CW'(C - 1)) begin
                    bias_ext = AW'($signed(b_data[l * N_LEN +: N_LEN]));
                    shr      = (sum + (bias_ext <<< FRAC)) >>> FRAC;
                    if (shr > SMAX) begin
                        res = SMAX[N_LEN-1:0];
                    end else if (shr < SMIN) begin
                        res = SMIN[N_LEN-1:0];
                    end else begin
                        res = shr[N_LEN-1:0];
                    end
                    if (RELU != 0 && res[N_LEN-1]) begin
                        res = '0;
                    end
                    work_d[(int'(rd_g_q) * N_LANES + l) * N_LEN +: N_LEN] = res;
                end
            end
        end

        // The last group is finalized in DRAIN, so publish work_d, not work_q.
        out_d    = (st_q == DRAIN) ? work_d : out_q;

        busy_d   = (st_d == ISSUE) || (st_d == DRAIN);
        valid_d  = (st_d == DONE);
        w_addr_d = (st_d == ISSUE) ? {bank_d, g_d, c_d} : '0;
        b_addr_d = (st_d == ISSUE) ? {bank_d, g_d} : '0;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            st_q     <= IDLE;
            g_q      <= '0;
            c_q      <= '0;
            bank_q   <= '0;
            data_q   <= '0;
            rd_vld_q <= 1'b0;
            rd_g_q   <= '0;
            rd_c_q   <= '0;
            for (int l = 0; l < N_LANES; l++) begin
                acc_q[l] <= '0;
            end
            work_q   <= '0;
            out_q    <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            w_addr_q <= '0;
            b_addr_q <= '0;
        end else begin
            st_q     <= st_d;
            g_q      <= g_d;
            c_q      <= c_d;
            bank_q   <= bank_d;
            data_q   <= data_d;
            rd_vld_q <= rd_vld_d;
            rd_g_q   <= rd_g_d;
            rd_c_q   <= rd_c_d;
            for (int l = 0; l < N_LANES; l++) begin
                acc_q[l] <= acc_d[l];
            end
            work_q   <= work_d;
            out_q    <= out_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            w_addr_q <= w_addr_d;
            b_addr_q <= b_addr_d;
        end
    end

    assign busy     = busy_q;
    assign valid    = valid_q;
    assign data_out = out_q;
    assign w_addr   = w_addr_q;
    assign b_addr   = b_addr_q;

endmodule

// File: tb/tb_mix_engine.sv
// tb/tb_mix_engine.sv - directed self-checking bench for mix_engine
module tb_mix_engine;

    localparam int HID = 24, DN = 8, NL = 16, LN = 4, SL = 3;
    localparam int G = 6, C = 3, GW = 3, CW = 2;
    localparam int WA = SL + GW + CW, BA = SL + GW;
    localparam int VW = HID * NL, WW = LN * DN * NL, BW = LN * NL;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          run = 1'b0;
    logic [SL-1:0] state = '0;
    logic [VW-1:0] din = '0;

    logic          busy0, valid0, busy1, valid1;
    logic [VW-1:0] dout0, dout1;
    logic [WA-1:0] wa0, wa1, wa0_r, wa1_r;
    logic [BA-1:0] ba0, ba1, ba0_r, ba1_r;
    logic [WW-1:0] wd0, wd1;
    logic [BW-1:0] bd0, bd1;

    int wmode = 0;
    int bmode = 0;
    int total = 0;
    int bad = 0;
    int mis_addr, out_changes, lat, nval;
    logic busy_t1;
    logic [VW-1:0] ident, expv, relv;

    always #5 clk = ~clk;

    // Weight modes: 0 identity (1.0 diagonal), 1 all 0x7FFF, 2 zero, 3 all 1 LSB.
    function automatic logic [WW-1:0] rom_w(input logic [WA-1:0] a, input int mode);
        logic [WW-1:0] w;
        logic [NL-1:0] v;
        int g, c;
        w = '0;
        g = int'(a[CW+GW-1:CW]);
        c = int'(a[CW-1:0]);
        for (int l = 0; l < LN; l++) begin
            for (int k = 0; k < DN; k++) begin
                case (mode)
                    0:       v = ((g * LN + l) == (c * DN + k)) ? 16'd256 : 16'd0;
                    1:       v = 16'h7FFF;
                    3:       v = 16'h0001;
                    default: v = 16'h0000;
                endcase
                w[(l * DN + k) * NL +: NL] = v;
            end
        end
        return w;
    endfunction

    // Bias modes: 0 zero, 1 bias[j] = j.
    function automatic logic [BW-1:0] rom_b(input logic [BA-1:0] a, input int mode);
        logic [BW-1:0] b;
        b = '0;
        for (int l = 0; l < LN; l++) begin
            b[l * NL +: NL] = (mode == 1) ? NL'(int'(a[GW-1:0]) * LN + l) : '0;
        end
        return b;
    endfunction

    function automatic logic [VW-1:0] fill(input logic [NL-1:0] v);
        logic [VW-1:0] r;
        for (int i = 0; i < HID; i++) r[i * NL +: NL] = v;
        return r;
    endfunction

    always @(posedge clk) begin
        wa0_r <= wa0;
        wa1_r <= wa1;
        ba0_r <= ba0;
        ba1_r <= ba1;
    end

    assign wd0 = rom_w(wa0_r, wmode);
    assign wd1 = rom_w(wa1_r, wmode);
    assign bd0 = rom_b(ba0_r, bmode);
    assign bd1 = rom_b(ba1_r, bmode);

    mix_engine #(.RELU(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .run(run), .state(state), .data_in(din),
        .busy(busy0), .valid(valid0), .data_out(dout0),
        .w_addr(wa0), .w_data(wd0), .b_addr(ba0), .b_data(bd0)
    );

    mix_engine #(.RELU(1)) u_relu (
        .clk(clk), .rst_n(rst_n), .run(run), .state(state), .data_in(din),
        .busy(busy1), .valid(valid1), .data_out(dout1),
        .w_addr(wa1), .w_data(wd1), .b_addr(ba1), .b_data(bd1)
    );

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge in IDLE/DONE; returns at the negedge where valid0
    // is seen (or after the cycle budget). Address sequence and data_out
    // stability are tallied into mis_addr / out_changes.
    task automatic run_and_wait(input int pulse_at, input int chg_at,
                                input logic [VW-1:0] chg_val, output int n);
        logic [VW-1:0] out_start;
        logic [SL-1:0] bank;
        logic [WA-1:0] ew;
        logic [BA-1:0] eb;
        out_start   = dout0;
        bank        = state;
        mis_addr    = 0;
        out_changes = 0;
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        n = 1;
        busy_t1 = busy0;
        while (!valid0 && n < 60) begin
            run = (n == pulse_at);
            if (n == chg_at) begin
                din   = chg_val;
                state = ~state;
            end
            ew = (n <= G * C) ? {bank, GW'((n - 1) / C), CW'((n - 1) % C)} : '0;
            eb = (n <= G * C) ? {bank, GW'((n - 1) / C)} : '0;
            if (wa0 !== ew || ba0 !== eb) mis_addr++;
            if (dout0 !== out_start) out_changes++;
            @(negedge clk);
            n++;
        end
        run = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < HID; i++) begin
            ident[i * NL +: NL] = NL'(i * 256 - 3000);
            relv[i * NL +: NL]  = (i * 256 - 3000 < 0) ? '0 : NL'(i * 256 - 3000);
        end

        // Reset held for two edges.
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        chk("rst_busy", busy0, 0);
        chk("rst_valid", valid0, 0);
        chk("rst_dout", dout0, 0);
        chk("rst_waddr", wa0, 0);

        // Identity weights, zero bias.
        wmode = 0; bmode = 0; state = 3'd0; din = ident;
        run_and_wait(-1, -1, '0, lat);
        chk("id_latency", lat, 20);
        chk("id_dout", dout0, ident);
        chk("id_relu_dout", dout1, relv);
        chk("id_busy_t1", busy_t1, 1);
        chk("id_busy_done", busy0, 0);
        chk("id_addr_seq", mis_addr, 0);
        chk("id_dout_stable", out_changes, 0);
        @(negedge clk);
        chk("id_valid_single", valid0, 0);
        chk("id_waddr_idle", wa0, 0);

        // Positive saturation.
        wmode = 1; din = fill(16'h7FFF);
        run_and_wait(-1, -1, '0, lat);
        chk("sat_pos", dout0, fill(16'h7FFF));
        // Negative saturation; ReLU clamps to zero.
        din = fill(16'h8000);
        run_and_wait(-1, -1, '0, lat);
        chk("sat_neg", dout0, fill(16'h8000));
        chk("sat_neg_relu", dout1, '0);
        // -24 LSB >>> 8 floors to -1.
        wmode = 3; din = fill(16'hFFFF);
        run_and_wait(-1, -1, '0, lat);
        chk("floor_neg", dout0, fill(16'hFFFF));
        chk("floor_relu", dout1, '0);

        // Zero weights, bias[j] = j.
        wmode = 2; bmode = 1; din = ident;
        for (int j = 0; j < HID; j++) expv[j * NL +: NL] = NL'(j);
        run_and_wait(-1, -1, '0, lat);
        chk("bias_only", dout0, expv);

        // Bank 5, stray run at T5, data_in/state changed at T2.
        wmode = 0; bmode = 1; state = 3'd5; din = ident;
        for (int j = 0; j < HID; j++) expv[j * NL +: NL] = NL'(j * 256 - 3000 + j);
        run_and_wait(5, 2, fill(16'h1234), lat);
        chk("bank5_addr_seq", mis_addr, 0);
        chk("bank5_latency", lat, 20);
        chk("bank5_dout", dout0, expv);
        nval = 0;
        for (int t = 0; t < 25; t++) begin
            @(negedge clk);
            if (valid0) nval++;
        end
        chk("stray_run_one_valid", nval, 0);

        // Back-to-back: run held in the DONE cycle.
        bmode = 0; state = 3'd0; din = ident;
        run_and_wait(-1, -1, '0, lat);
        chk("b2b_first", dout0, ident);
        chk("b2b_valid_in_done", valid0, 1);
        din = fill(16'h0100);
        run_and_wait(-1, -1, '0, lat);
        chk("b2b_busy_next", busy_t1, 1);
        chk("b2b_latency", lat, 20);
        chk("b2b_old_held", out_changes, 0);
        chk("b2b_second", dout0, fill(16'h0100));

        // Reset at T0+10 with run asserted in the reset cycle.
        din = ident;
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b1;
        run = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        run = 1'b0;
        chk("midrst_busy", busy0, 0);
        chk("midrst_dout", dout0, 0);
        chk("midrst_valid", valid0, 0);
        nval = 0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (valid0 || busy0) nval++;
        end
        chk("midrst_quiet", nval, 0);
        run_and_wait(-1, -1, '0, lat);
        chk("post_rst_latency", lat, 20);
        chk("post_rst_dout", dout0, ident);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
